// File: rtl/osl_tx_arbiter.sv
// rtl/osl_tx_arbiter.sv - round-robin arbiter sharing one osl_rxtx transmit host port
module osl_tx_arbiter #(
    parameter int WORDSZ  = 32,
    parameter int NREQ    = 4,
    parameter int IDW     = 2,
    parameter int TIMEOUT = 1023
) (
    input  logic                   clk,
    input  logic                   resetb,
    input  logic [NREQ-1:0]        req,
    input  logic [NREQ*WORDSZ-1:0] req_data,
    output logic [NREQ-1:0]        ack,
    output logic [IDW-1:0]         grant_id,
    input  logic                   link_dir,
    output logic                   link_wr,
    output logic [WORDSZ-1:0]      link_din,
    output logic                   busy,
    output logic                   timeout_err
);

    typedef enum logic [1:0] {IDLE, HOLD, DRAIN} state_t;

    localparam logic [15:0] TIMEOUT_CNT = 16'(TIMEOUT);

    state_t              state_q;
    logic [15:0]         cnt_q;
    logic [IDW-1:0]      grant_id_q;
    logic [NREQ-1:0]     ack_q;
    logic                link_wr_q;
    logic [WORDSZ-1:0]   link_din_q;
    logic                timeout_err_q;

    logic [WORDSZ-1:0]   data_a [NREQ];
    logic                win_vld;
    logic [IDW-1:0]      win_id;

    for (genvar i = 0; i < NREQ; i++) begin : g_unpack
        assign data_a[i] = req_data[i*WORDSZ +: WORDSZ];
    end

    // Scan starts one past the last grant, so the last winner has lowest priority.
    always_comb begin
        win_vld = 1'b0;
        win_id  = '0;
        for (int k = 1; k <= NREQ; k++) begin
            logic [IDW-1:0] cand;
            cand = IDW'((int'(grant_id_q) + k) % NREQ);
            if (!win_vld && req[cand]) begin
                win_vld = 1'b1;
                win_id  = cand;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!resetb) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            grant_id_q    <= IDW'(NREQ - 1);
            ack_q         <= '0;
            link_wr_q     <= 1'b0;
            link_din_q    <= '0;
            timeout_err_q <= 1'b0;
        end else begin
            ack_q         <= '0;
            link_wr_q     <= 1'b0;
            timeout_err_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (link_dir && win_vld) begin
                        link_din_q <= data_a[win_id];
                        link_wr_q  <= 1'b1;
                        ack_q      <= NREQ'(1) << win_id;
                        grant_id_q <= win_id;
                        cnt_q      <= '0;
                        state_q    <= HOLD;
                    end
                end
                HOLD: begin
                    cnt_q <= cnt_q + 16'd1;
                    if (!link_dir) begin
                        state_q <= DRAIN;
                    end else if (cnt_q + 16'd1 == TIMEOUT_CNT) begin
                        // Word counts as delivered; no retry.
                        timeout_err_q <= 1'b1;
                        state_q       <= IDLE;
                    end
                end
                DRAIN: begin
                    if (link_dir) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign ack         = ack_q;
    assign grant_id    = grant_id_q;
    assign link_wr     = link_wr_q;
    assign link_din    = link_din_q;
    assign busy        = (state_q != IDLE);
    assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_osl_tx_arbiter.sv
// tb/tb_osl_tx_arbiter.sv - scoreboard bench for osl_tx_arbiter with a looped-back link model
module tb_osl_tx_arbiter;

    localparam int WORDSZ = 32;
    localparam int NREQ   = 4;
    localparam int IDW    = 2;

    typedef struct {
        logic [IDW-1:0]    id;
        logic [WORDSZ-1:0] data;
    } grant_t;

    logic                   clk = 1'b0;
    logic                   resetb;
    logic [NREQ-1:0]        req;
    logic [NREQ*WORDSZ-1:0] req_data;
    logic [NREQ-1:0]        ack;
    logic [IDW-1:0]         grant_id;
    logic                   link_dir;
    logic                   link_wr;
    logic [WORDSZ-1:0]      link_din;
    logic                   busy;
    logic                   timeout_err;

    logic                   model_dir = 1'b1;
    int                     model_cnt = 0;
    logic                   ovr_en = 1'b0;
    logic                   ovr_val = 1'b0;

    grant_t                 exp_q[$];
    logic [WORDSZ-1:0]      far_exp_q[$];
    int                     n_checks = 0;
    int                     n_fail = 0;
    int                     n_acks = 0;

    assign link_dir = ovr_en ? ovr_val : model_dir;

    osl_tx_arbiter #(.WORDSZ(WORDSZ), .NREQ(NREQ), .IDW(IDW), .TIMEOUT(15)) dut (
        .clk(clk), .resetb(resetb), .req(req), .req_data(req_data), .ack(ack),
        .grant_id(grant_id), .link_dir(link_dir), .link_wr(link_wr), .link_din(link_din),
        .busy(busy), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic expect_grant(input int id, input logic [WORDSZ-1:0] data);
        grant_t g;
        g.id   = IDW'(id);
        g.data = data;
        exp_q.push_back(g);
        far_exp_q.push_back(data);
    endtask

    task automatic wait_acks(input int target);
        int cyc;
        cyc = 0;
        while (n_acks < target && cyc < 200) begin
            @(negedge clk);
            #1;
            cyc++;
        end
        if (n_acks < target) check("ack_wait_timeout", 64'(n_acks), 64'(target));
    endtask

    task automatic settle();
        repeat (8) @(negedge clk);
        #1;
    endtask

    // Scoreboard monitor: every strobe pops one expected grant.
    always @(negedge clk) begin
        if (resetb && (ack != '0 || link_wr)) begin
            n_acks++;
            if (exp_q.size() == 0) begin
                check("unexpected_grant", {60'd0, ack}, 64'd0);
            end else begin
                grant_t g;
                g = exp_q.pop_front();
                check("ack", {60'd0, ack}, 64'(NREQ'(1) << g.id));
                check("grant_id", 64'(grant_id), 64'(g.id));
                check("link_wr", 64'(link_wr), 64'd1);
                check("link_din", 64'(link_din), 64'(g.data));
            end
        end
    end

    // Far-end link model: accepts the word, then holds dir low briefly.
    always @(negedge clk) begin
        if (link_wr) begin
            if (far_exp_q.size() == 0) check("far_unexpected", 64'(link_din), 64'd0);
            else check("far_dout", 64'(link_din), 64'(far_exp_q.pop_front()));
            model_dir = 1'b0;
            model_cnt = 2;
        end else if (model_cnt > 0) begin
            model_cnt--;
            if (model_cnt == 0) model_dir = 1'b1;
        end
    end

    initial begin
        int base;
        int found;
        resetb   = 1'b0;
        req      = '0;
        req_data = '0;
        repeat (3) @(negedge clk);
        #1;
        check("rst_ack", {60'd0, ack}, 64'd0);
        check("rst_grant_id", 64'(grant_id), 64'd3);
        check("rst_link_wr", 64'(link_wr), 64'd0);
        check("rst_link_din", 64'(link_din), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_timeout_err", 64'(timeout_err), 64'd0);
        resetb = 1'b1;
        settle();

        // 1: single request from requester 2
        req_data[2*WORDSZ +: WORDSZ] = 32'h0123_4567;
        expect_grant(2, 32'h0123_4567);
        base = n_acks;
        req = 4'b0100;
        wait_acks(base + 1);
        req = '0;
        settle();

        // 2: all requesting, rotation from pointer 2
        for (int i = 0; i < NREQ; i++) req_data[i*WORDSZ +: WORDSZ] = 32'h89AB_CDE0 + 32'(i);
        expect_grant(3, 32'h89AB_CDE3);
        expect_grant(0, 32'h89AB_CDE0);
        expect_grant(1, 32'h89AB_CDE1);
        expect_grant(2, 32'h89AB_CDE2);
        expect_grant(3, 32'h89AB_CDE3);
        base = n_acks;
        req = 4'b1111;
        wait_acks(base + 5);
        req = '0;
        settle();

        // 3: req0 held, req3 once -> 0,3,0
        req_data[0*WORDSZ +: WORDSZ] = 32'hA000_0000;
        req_data[3*WORDSZ +: WORDSZ] = 32'hB000_0003;
        expect_grant(0, 32'hA000_0000);
        expect_grant(3, 32'hB000_0003);
        expect_grant(0, 32'hA000_0000);
        base = n_acks;
        req = 4'b1001;
        wait_acks(base + 2);
        req = 4'b0001;
        wait_acks(base + 3);
        req = '0;
        settle();

        // 4: link_dir low blocks grants; release grants on the next edge
        ovr_en  = 1'b1;
        ovr_val = 1'b0;
        req_data[0*WORDSZ +: WORDSZ] = 32'h0000_C0DE;
        req = 4'b0001;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            #1;
            check("blocked_quiet", {58'd0, link_wr, ack, busy}, 64'd0);
        end
        expect_grant(0, 32'h0000_C0DE);
        ovr_en = 1'b0;
        @(negedge clk);
        #1;
        check("release_ack", {60'd0, ack}, 64'd1);
        req = '0;
        settle();

        // 5: link_dir stuck high -> timeout after 15 cycles in HOLD
        ovr_en  = 1'b1;
        ovr_val = 1'b1;
        req_data[1*WORDSZ +: WORDSZ] = 32'h5555_0001;
        expect_grant(1, 32'h5555_0001);
        base = n_acks;
        req = 4'b0010;
        wait_acks(base + 1);
        req = '0;
        found = 0;
        for (int c = 1; c <= 20 && found == 0; c++) begin
            @(negedge clk);
            #1;
            if (timeout_err) found = c;
            else if (c < 15) check("hold_busy", 64'(busy), 64'd1);
        end
        check("timeout_latency", 64'(found), 64'd15);
        @(negedge clk);
        #1;
        check("timeout_pulse_end", 64'(timeout_err), 64'd0);
        check("timeout_idle", 64'(busy), 64'd0);
        ovr_en = 1'b0;
        settle();

        // 6: reset mid-HOLD, then priority restarts at requester 0
        ovr_en  = 1'b1;
        ovr_val = 1'b1;
        req_data[2*WORDSZ +: WORDSZ] = 32'h6000_0002;
        expect_grant(2, 32'h6000_0002);
        base = n_acks;
        req = 4'b0100;
        wait_acks(base + 1);
        req = '0;
        repeat (3) @(negedge clk);
        #1;
        check("pre_reset_busy", 64'(busy), 64'd1);
        resetb = 1'b0;
        @(negedge clk);
        #1;
        resetb = 1'b1;
        ovr_en = 1'b0;
        check("midhold_rst_busy", 64'(busy), 64'd0);
        check("midhold_rst_grant_id", 64'(grant_id), 64'd3);
        check("midhold_rst_ack", {60'd0, ack}, 64'd0);
        req_data[0*WORDSZ +: WORDSZ] = 32'h6000_0000;
        req_data[1*WORDSZ +: WORDSZ] = 32'h6000_0001;
        expect_grant(0, 32'h6000_0000);
        expect_grant(1, 32'h6000_0001);
        base = n_acks;
        req = 4'b0011;
        wait_acks(base + 2);
        req = '0;
        settle();

        check("exp_q_empty", 64'(exp_q.size()), 64'd0);
        check("far_q_empty", 64'(far_exp_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
